// File: rtl/fifo_reg_pkg.sv
// fifo_reg_pkg: shared FIFO defaults (word width, depth, pointer width)
package fifo_reg_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/dff.sv
// dff: single-bit flop, sync active-high reset to 0; ports clk, rst, d -> q
module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : d;
endmodule

// File: rtl/fifo_ctl.sv
// fifo_ctl: FIFO pointers/count in dff flops, flag and error decode, write one-hot; ports clk, rst, push, pop -> rd_ptr, wr_ptr, count, empty, full, err, we
module fifo_ctl
  import fifo_reg_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [DEPTH-1:0] we
);
  localparam int CW = PTR_W + 1;
  localparam int SW = 2 * PTR_W + CW;
  logic             push_ok, pop_ok;
  logic [PTR_W-1:0] rd_n, wr_n;
  logic [CW-1:0]    count_n;
  logic [SW-1:0]    st_d, st_q;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign err     = (push && full && !pop) || (pop && empty);
  assign rd_n    = rd_ptr + PTR_W'(pop_ok);
  assign wr_n    = wr_ptr + PTR_W'(push_ok);
  assign count_n = count + CW'(push_ok) - CW'(pop_ok);
  assign st_d    = {count_n, wr_n, rd_n};
  assign {count, wr_ptr, rd_ptr} = st_q;
  for (genvar i = 0; i < SW; i++) begin : g_st
    dff u_dff (.clk(clk), .rst(rst), .d(st_d[i]), .q(st_q[i]));
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_we
    assign we[i] = push_ok && wr_ptr == PTR_W'(i);
  end
endmodule

// File: rtl/fifo_reg.sv
// fifo_reg: first-word fall-through FIFO on dff storage; ports clk, rst, data_in, push, pop -> data_out, empty, full, count, err
module fifo_reg
  import fifo_reg_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             err
);
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] row_d [DEPTH];
  logic [WIDTH-1:0] row_q [DEPTH];
  fifo_ctl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctl (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .count(count),
    .empty(empty), .full(full), .err(err), .we(we)
  );
  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    assign row_d[r] = we[r] ? data_in : row_q[r];
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      dff u_dff (.clk(clk), .rst(rst), .d(row_d[r][b]), .q(row_q[r][b]));
    end
  end
  assign data_out = empty ? '0 : row_q[rd_ptr];
endmodule

// File: doc/fifo_reg.md
Name: fifo_reg

Overview:
- DEPTH-entry, WIDTH-bit synchronous FIFO with first-word fall-through output.
- Sits upstream of the pipeline/holding registers: buffers producer words and presents the head word to the consumer register stage.
- Storage is built from the team's single-bit dff primitive only: no latches, no behavioural memory arrays.

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH, 4: number of entries. Must be a power of two, at least 2.
- PTR_W, 2: pointer width, log2(DEPTH). The count is PTR_W+1 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  word to enqueue.
- push  in  1  enqueue request this cycle.
- pop  in  1  dequeue request this cycle.
- data_out  out  WIDTH  head entry (combinational from storage); 0 when empty.
- empty  out  1  no valid entries.
- full  out  1  DEPTH valid entries.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- err  out  1  illegal request this cycle (combinational).

Behaviour:
- Reset (rst=1 at a rising edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Outputs after reset: empty=1, full=0, data_out=0, err=0.
  - Storage contents are cleared to 0.
  - rst overrides push/pop in the same cycle; reset mid-operation discards all entries.
- State: rd_ptr and wr_ptr (PTR_W bits each) plus count (PTR_W+1 bits), all held in dff flops.
  - Pointers wrap modulo DEPTH naturally: DEPTH-1 increments to 0.
  - empty = (count==0); full = (count==DEPTH). Both are decoded combinationally from count.
- Accepted push: push=1 and (!full or pop=1).
  - mem[wr_ptr] <= data_in; wr_ptr += 1.
- Accepted pop: pop=1 and !empty.
  - rd_ptr += 1. The popped word is the data_out visible during that same cycle.
- count update:
  - Accepted push only: +1.
  - Accepted pop only: -1.
  - Both accepted: unchanged.
- Simultaneous push+pop:
  - When full: both accepted. Head leaves, new word written into the freed slot (wr_ptr==rd_ptr). full stays 1, count stays DEPTH.
  - When empty: pop rejected, push accepted. count becomes 1; err=1 for that cycle.
  - No bypass: data_in never appears on data_out in the cycle it is pushed. It appears the next cycle.
- Illegal cases:
  - push=1, full=1, pop=0: write dropped, no state change, err=1.
  - pop=1, empty=1: no pointer change, err=1.
  - err is purely combinational and not sticky.
- Latency: a word pushed in cycle N is on data_out in cycle N+1 if the FIFO was empty.
- data_out = mem[rd_ptr] when !empty, else 0. A mux driven from the flop outputs; no extra register stage.
- Every flop updates each cycle through its next-state mux; no gated clocks.

Decomposition:
- Shared include file: FIFO_DEPTH and FIFO_WIDTH defaults, plus a constant for the pointer width.
- One natural sub-module, fifo_ctl: owns rd_ptr, wr_ptr, count, full/empty/err decode and the write-enable one-hot.
- fifo_reg instantiates:
  - fifo_ctl;
  - DEPTH rows of WIDTH dff flops, each with an enable mux;
  - the read mux.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, data_out=0, err=0 for 3 cycles.
- Push 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
  - data_out=0x1111 from the cycle after the first push.
  - After the 4th push: full=1, count=4.
  - Then pop 4 times: data_out sequence 0x1111, 0x2222, 0x3333, 0x4444, then empty=1.
- Full FIFO, push 0xBEEF alone → err=1 that cycle, count stays 4. Subsequent pops never return 0xBEEF.
- Full FIFO, push 0xAAAA + pop same cycle → count stays 4, head advances. Following 4 pops end with 0xAAAA.
- Empty FIFO, pop + push 0x5555 same cycle → err=1, count=1. Next cycle data_out=0x5555, err=0.
- Wrap-around and reset:
  - Run 10 push/pop pairs interleaved with 2-deep occupancy → FIFO order preserved across pointer wrap.
  - Assert rst with count=3 → next cycle count=0, empty=1, data_out=0.
